// File: rtl/au_digit_serial_adder.sv
// Digit-serial adder: computes a + b + ci over ceil(WIDTH/DIGIT) cycles, LSB digit first,
// and reports the registered sum, carry-out and an all-zeros flag on a one-cycle done pulse.
module au_digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             z
);

  localparam int N         = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW        = N * DIGIT;
  localparam int CW        = (N > 1) ? $clog2(N) : 1;
  localparam int LAST_BITS = WIDTH - (N - 1) * DIGIT;
  localparam logic [DIGIT-1:0] LAST_MASK = {DIGIT{1'b1}} >> (DIGIT - LAST_BITS);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(N - 1);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "au_digit_serial_adder: WIDTH=%0d is illegal, must be >= 1", WIDTH);
  end
  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $fatal(1, "au_digit_serial_adder: DIGIT=%0d is illegal, must be in 1..WIDTH (%0d)",
           DIGIT, WIDTH);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   a_sh, b_sh, sum_sh, sum_next;
  logic [CW-1:0]   cnt;
  logic            carry, zero, last;
  logic [DIGIT:0]  dsum;
  logic [DIGIT-1:0] dbits;

  assign busy = (state == RUN);

  // Operands shift right so the current digit is always at the bottom; the sum shifts in
  // from the top so that after N digits it sits LSB-aligned.
  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    last     = (cnt == CNT_LAST);
    dbits    = last ? (dsum[DIGIT-1:0] & LAST_MASK) : dsum[DIGIT-1:0];
    sum_next = (sum_sh >> DIGIT) | (PW'(dbits) << (PW - DIGIT));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      co     <= 1'b0;
      z      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh   <= PW'(a);
          b_sh   <= PW'(b);
          carry  <= ci;
          cnt    <= '0;
          sum_sh <= '0;
          zero   <= 1'b1;
        end
      end else begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        carry  <= dsum[DIGIT];
        zero   <= zero & (dbits == '0);
        sum_sh <= sum_next;
        cnt    <= cnt + 1'b1;
        if (last) begin
          // On a short last digit the carry out of bit WIDTH-1 lands at LAST_BITS.
          done <= 1'b1;
          s    <= sum_next[WIDTH-1:0];
          co   <= dsum[LAST_BITS];
          z    <= zero & (dbits == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_au_digit_serial_adder.sv
// Bench for au_digit_serial_adder: directed scenarios plus randomized back-to-back traffic
// over several WIDTH/DIGIT configurations, checked against an integer-arithmetic model.
module tb_au_digit_serial_adder;

  localparam int NI = 5;
  localparam int WID [NI] = '{8, 16, 13, 1, 8};
  localparam int DIG [NI] = '{3, 4, 5, 1, 8};
  localparam int NDG [NI] = '{3, 4, 3, 1, 1};
  localparam int N_RAND = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_v [NI];
  logic [15:0] a_v [NI];
  logic [15:0] b_v [NI];
  logic        ci_v [NI];
  logic        busy_v [NI];
  logic        done_v [NI];
  logic        co_v [NI];
  logic        z_v [NI];
  logic [15:0] s_v [NI];

  logic [15:0] exp_s [NI];
  logic        exp_co [NI];
  logic        exp_z [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [WID[g]-1:0] s_l;
    au_digit_serial_adder #(.WIDTH(WID[g]), .DIGIT(DIG[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .a     (a_v[g][WID[g]-1:0]),
      .b     (b_v[g][WID[g]-1:0]),
      .ci    (ci_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .s     (s_l),
      .co    (co_v[g]),
      .z     (z_v[g])
    );
    assign s_v[g] = 16'(s_l);
  end

  // Returns {z, co, s} for a w-bit addition using plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [16:0] mask, full, sm;
    mask = (17'd1 << w) - 17'd1;
    full = (17'(a) & mask) + (17'(b) & mask) + 17'(ci);
    sm   = full & mask;
    return {sm == 17'd0, full[w], sm[15:0]};
  endfunction

  task automatic clear_expect();
    for (int i = 0; i < NI; i++) begin
      exp_s[i] = '0; exp_co[i] = 1'b0; exp_z[i] = 1'b0;
    end
  endtask

  // Issues one request (called when the instance is idle or in its done cycle) and checks
  // accept, output hold while running, latency and the final result.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input string name);
    logic [17:0] m;
    int          c;
    bit          seen;
    m = model(WID[i], a, b, ci);
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; ci_v[i] = ci;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    a_v[i] = 16'($urandom); b_v[i] = 16'($urandom); ci_v[i] = 1'($urandom);
    n_cmp++;
    if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy_v[i], done_v[i]);
    end
    seen = 0;
    for (c = 1; c <= NDG[i] + 4; c++) begin
      @(posedge clk); #1;
      if (done_v[i] === 1'b1) begin
        seen = 1;
        break;
      end
      n_cmp++;
      if ({busy_v[i], s_v[i], co_v[i], z_v[i]} !== {1'b1, exp_s[i], exp_co[i], exp_z[i]}) begin
        n_bad++;
        $display("FAIL %s hold c=%0d: busy=%b s=%h co=%b z=%b, want busy=1 s=%h co=%b z=%b",
                 name, c, busy_v[i], s_v[i], co_v[i], z_v[i], exp_s[i], exp_co[i], exp_z[i]);
      end
    end
    n_cmp++;
    if (!seen || c != NDG[i]) begin
      n_bad++;
      $display("FAIL %s latency: done seen=%0d after %0d cycles, want %0d", name, seen, c, NDG[i]);
    end
    n_cmp++;
    if ({busy_v[i], s_v[i], co_v[i], z_v[i]} !== {1'b0, m[15:0], m[16], m[17]}) begin
      n_bad++;
      $display("FAIL %s result a=%h b=%h ci=%b: busy=%b s=%h co=%b z=%b, want busy=0 s=%h co=%b z=%b",
               name, a, b, ci, busy_v[i], s_v[i], co_v[i], z_v[i], m[15:0], m[16], m[17]);
    end
    exp_s[i] = m[15:0]; exp_co[i] = m[16]; exp_z[i] = m[17];
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], s_v[i], co_v[i], z_v[i]} !== 20'd0) begin
        n_bad++;
        $display("FAIL %s inst%0d: busy=%b done=%b s=%h co=%b z=%b, want all 0",
                 name, i, busy_v[i], done_v[i], s_v[i], co_v[i], z_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; ci_v[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_expect();
  endtask

  task automatic test_basic();
    do_op(0, 16'h00, 16'h00, 1'b0, "zero_add");
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_v[0], done_v[0], s_v[0], co_v[0], z_v[0]} !== {2'b00, 16'h0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL done_clear: busy=%b done=%b s=%h co=%b z=%b, want busy=0 done=0 s=0000 co=0 z=1",
               busy_v[0], done_v[0], s_v[0], co_v[0], z_v[0]);
    end
    do_op(0, 16'hFF, 16'h00, 1'b1, "wrap_zero");
    do_op(0, 16'h5A, 16'hA5, 1'b0, "all_ones");
  endtask

  task automatic test_busy_ignore();
    int  c;
    bit  seen;
    start_v[0] = 1'b1; a_v[0] = 16'h01; b_v[0] = 16'h01; ci_v[0] = 1'b0;
    @(posedge clk); #1;
    a_v[0] = 16'h80; b_v[0] = 16'h80;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    seen = 0;
    for (c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen || c != 3) begin
      n_bad++;
      $display("FAIL busy_ignore latency: seen=%0d c=%0d, want done at 3", seen, c);
    end
    n_cmp++;
    if ({s_v[0], co_v[0], z_v[0]} !== {16'h0002, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL busy_ignore result: s=%h co=%b z=%b, want s=0002 co=0 z=0",
               s_v[0], co_v[0], z_v[0]);
    end
    exp_s[0] = 16'h0002; exp_co[0] = 1'b0; exp_z[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_op(0, 16'h80, 16'h80, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_run();
    bit bad;
    start_v[0] = 1'b1; a_v[0] = 16'h7F; b_v[0] = 16'h01; ci_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_all_zero("reset_mid_run");
    clear_expect();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL reset_abort: done/busy seen after mid-run reset, want none");
    end
  endtask

  task automatic test_edge_sizes();
    do_op(3, 16'h1, 16'h0, 1'b1, "w1d1");
    do_op(4, 16'hC3, 16'h3D, 1'b0, "w8d8_carry");
    do_op(4, 16'h12, 16'h34, 1'b1, "w8d8_plain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N_RAND; k++) begin
        do_op(i, 16'($urandom), 16'($urandom), 1'($urandom), "random");
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_edge_sizes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
